mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one cache2mem memory port, and therefore one AXI master, between the D-cache (requester 0) and the I-cache (requester 1). It sits between the two cache controllers and the AXI master wrapper. It grants one requester at a time and holds the grant for the whole transaction, counting beats so it releases only after the last read beat or the write response. The downstream request is masked on the final beat so the master never chains a duplicate transaction.

## Interface
- Parameters: none; widths come from the AXI/cpu packages (ADDR 32, DATA 32, TYPE 3 = Func3BusWidth, LEN 4 = AXI_LEN_BITS)
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_i[1:0]  in  2  request per requester (index 0 = D-cache, 1 = I-cache)
- write_i[1:0]  in  2  1 = write, 0 = read
- addr0_i / addr1_i  in  32  byte address
- wdata0_i / wdata1_i  in  32  write data
- type0_i / type1_i  in  3  store type (OP_SB/OP_SH/OP_SW)
- blk0_i / blk1_i  in  4  read burst length − 1
- rdata_o  out  32  read data, broadcast to both requesters
- wait_o[1:0]  out  2  beat/response strobe, only to the granted requester
- mem_req  out  1  to master m_req
- mem_write  out  1  to master m_write
- mem_addr  out  32  to master m_addr
- mem_in  out  32  to master m_in
- mem_type  out  3  to master m_type
- mem_blk_size  out  4  to master m_blk_size
- mem_out  in  32  from master m_out
- mem_wait  in  1  from master m_wait: one pulse per read beat or per B response
- grant_o  out  2  one-hot current owner, 00 when idle; debug and verification only

## Operation
- FSM states:
  - IDLE: no owner; all mem_* outputs 0; wait_o = 00.
  - BUSY: requester g owns the port.
- IDLE → BUSY when req_i ≠ 00. On that edge the arbiter:
  - registers winner g;
  - loads beat counter cnt (4 bits): 0 when write_i[g], else blk{g}_i.
- Winner selection: req_i == 01 → 0; req_i == 10 → 1; req_i == 11 → see Configuration.
- BUSY datapath:
  - mem_write, mem_addr, mem_in, mem_type, mem_blk_size pass through combinationally from requester g.
  - mem_req = req_i[g] & ~(mem_wait & cnt == 0).
  - rdata_o = mem_out always.
  - wait_o[g] = mem_wait; wait_o[~g] = 0.
- BUSY counting, on each mem_wait:
  - cnt ≠ 0 → decrement cnt and stay in BUSY.
  - cnt == 0 → go to IDLE; update the priority pointer.
- If req_i[g] drops while BUSY, the grant is still held. The master completes the burst, and the remaining beats are counted normally.
- A request on the other port during BUSY waits. It is never forwarded.
- mem_wait in IDLE is ignored and never reaches wait_o.

## Timing
- Reset values: state IDLE, grant_o 00, cnt 0, priority pointer → requester 0, mem_req 0, all mem_* outputs 0, wait_o 00.
- Arbitration latency: 1 cycle. A request first seen in IDLE at edge N produces mem_req = 1 from cycle N+1.
- Release:
  - The final-beat cycle has mem_req forced to 0. This prevents the master's last-beat/B-state lookahead from re-issuing the transaction.
  - After a release, the FSM is in IDLE for exactly 1 cycle, so back-to-back transactions are separated by ≥1 idle cycle on mem_req.
- Read with blk = N: exactly N+1 mem_wait pulses before release. A write: exactly 1 pulse.
- cnt never wraps. Release occurs at cnt == 0 before any decrement.
- Reset mid-transaction: immediate return to reset values. The AXI master is reset by the same rstn.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - The pointer flips to the non-served requester on every release.
  - When req_i == 11, the pointer's requester wins.
- MEM_ARB_RR_EN undefined: fixed priority.
  - The D-cache (0) always wins on req_i == 11.
  - The pointer register is not implemented.

## Test plan
- **Single read:** req_i = 10, write_i[1] = 0, addr1 = 0x0000_1000, blk1 = 3.
  - mem_req rises 1 cycle later with mem_addr = 0x1000 and mem_blk_size = 3.
  - Four mem_wait pulses reach wait_o[1] with rdata_o = mem_out.
  - mem_req is 0 on the 4th pulse; grant_o returns to 00.
- **Single write:** req_i = 01, write_i[0] = 1, addr0 = 0x2002, type0 = OP_SH, wdata0 = 0xABCD.
  - mem_write = 1 and the fields pass through.
  - One mem_wait releases the grant; wait_o[1] stays 0 throughout.
- **Contention, fixed priority (macro undefined):** req_i = 11 held across three transactions → requester 0 is granted every time.
- **Contention, round-robin (MEM_ARB_RR_EN):** req_i = 11 held → grants alternate 0, 1, 0.
  - Each grant is separated by exactly 1 IDLE cycle.
  - No duplicate mem_req on any last beat.
- **Request drop and late competitor:** granted requester 1 (blk = 7) drops req_i[1] after beat 2, and req_i[0] rises at the same time.
  - Grant is held until the 8th mem_wait.
  - Requester 0 is granted on the cycle after the IDLE cycle.
- **Reset mid-burst:** rstn asserted after beat 1 of a 4-beat read → next cycle all outputs are at reset values and grant_o = 00.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache2mem port bundle between mem_arbiter and the AXI master wrapper
//
// Purpose: groups the single shared memory port that the arbiter drives
// towards the AXI master wrapper.
// Signals:
//   mem_req       arbiter -> master  request (m_req)
//   mem_write     arbiter -> master  1 = write, 0 = read (m_write)
//   mem_addr      arbiter -> master  byte address (m_addr)
//   mem_in        arbiter -> master  write data (m_in)
//   mem_type      arbiter -> master  store type (m_type)
//   mem_blk_size  arbiter -> master  read burst length - 1 (m_blk_size)
//   mem_out       master -> arbiter  read data (m_out)
//   mem_wait      master -> arbiter  one pulse per read beat or B response (m_wait)
// Modports: master = arbiter side, slave = AXI master wrapper side.

interface mem_arbiter_if;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic [2:0]  mem_type;
  logic [3:0]  mem_blk_size;
  logic [31:0] mem_out;
  logic        mem_wait;

  modport master (
    output mem_req, mem_write, mem_addr, mem_in, mem_type, mem_blk_size,
    input  mem_out, mem_wait
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_in, mem_type, mem_blk_size,
    output mem_out, mem_wait
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter sharing one cache2mem port (D-cache 0, I-cache 1)
//
// Purpose: grants the memory port to one requester at a time and holds the
// grant for the whole transaction, counting mem_wait beats so it releases
// only after the last read beat or the write response.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration; without
// it requester 0 has fixed priority and no pointer register exists.
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   req_i[1:0], write_i[1:0]       per-requester request and direction
//   addr0_i/addr1_i                byte address
//   wdata0_i/wdata1_i              write data
//   type0_i/type1_i                store type
//   blk0_i/blk1_i                  read burst length - 1
//   rdata_o                        read data, broadcast to both requesters
//   wait_o[1:0]                    beat/response strobe to the granted requester
//   grant_o[1:0]                   one-hot owner, 00 when idle
//   mem                            downstream port (mem_arbiter_if.master)

module mem_arbiter (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [1:0]           req_i,
  input  logic [1:0]           write_i,
  input  logic [31:0]          addr0_i,
  input  logic [31:0]          addr1_i,
  input  logic [31:0]          wdata0_i,
  input  logic [31:0]          wdata1_i,
  input  logic [2:0]           type0_i,
  input  logic [2:0]           type1_i,
  input  logic [3:0]           blk0_i,
  input  logic [3:0]           blk1_i,
  output logic [31:0]          rdata_o,
  output logic [1:0]           wait_o,
  output logic [1:0]           grant_o,
  mem_arbiter_if.master        mem
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t     state;
  logic       gnt;     // current owner index, valid in S_BUSY
  logic [3:0] cnt;     // beats still expected after the current one
  logic       winner;
  logic       busy;
  logic       last_beat;

`ifdef MEM_ARB_RR_EN
  logic ptr;           // requester that wins a tie next time

  always_comb begin
    winner = req_i[0] ? (req_i[1] & ptr) : 1'b1;
  end
`else
  always_comb begin
    winner = ~req_i[0];
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      gnt     <= 1'b0;
      cnt     <= 4'd0;
      grant_o <= 2'b00;
`ifdef MEM_ARB_RR_EN
      ptr     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_i) begin
            state   <= S_BUSY;
            gnt     <= winner;
            // A write completes on its single B response.
            cnt     <= write_i[winner] ? 4'd0 : (winner ? blk1_i : blk0_i);
            grant_o <= winner ? 2'b10 : 2'b01;
          end
        end
        S_BUSY: begin
          if (mem.mem_wait) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              state   <= S_IDLE;
              grant_o <= 2'b00;
`ifdef MEM_ARB_RR_EN
              ptr     <= ~gnt;
`endif
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state == S_BUSY);
  assign last_beat = mem.mem_wait && (cnt == 4'd0);
  assign rdata_o   = mem.mem_out;

  always_comb begin
    mem.mem_req      = 1'b0;
    mem.mem_write    = 1'b0;
    mem.mem_addr     = 32'd0;
    mem.mem_in       = 32'd0;
    mem.mem_type     = 3'd0;
    mem.mem_blk_size = 4'd0;
    wait_o           = 2'b00;
    if (busy) begin
      // Masking the request on the final beat keeps the master's last-beat
      // lookahead from seeing a still-pending request and re-issuing it.
      mem.mem_req      = req_i[gnt] & ~last_beat;
      mem.mem_write    = write_i[gnt];
      mem.mem_addr     = gnt ? addr1_i  : addr0_i;
      mem.mem_in       = gnt ? wdata1_i : wdata0_i;
      mem.mem_type     = gnt ? type1_i  : type0_i;
      mem.mem_blk_size = gnt ? blk1_i   : blk0_i;
      wait_o[gnt]      = mem.mem_wait;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter

module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        who;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  typ;
    logic [3:0]  blk;
    bit          drop;
    bit          b2b;
    int          req_cyc;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [1:0]  req;
  logic [1:0]  wr;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  typ0, typ1;
  logic [3:0]  blk0, blk1;
  logic [31:0] rdata_o;
  logic [1:0]  wait_o;
  logic [1:0]  grant_o;

  mem_arbiter_if mif ();

  mem_arbiter dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_i    (req),
    .write_i  (wr),
    .addr0_i  (addr0),
    .addr1_i  (addr1),
    .wdata0_i (wdata0),
    .wdata1_i (wdata1),
    .type0_i  (typ0),
    .type1_i  (typ1),
    .blk0_i   (blk0),
    .blk1_i   (blk1),
    .rdata_o  (rdata_o),
    .wait_o   (wait_o),
    .grant_o  (grant_o),
    .mem      (mif)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   model_en = 0;
  logic dir_wait = 1'b0;
  logic m_ptr = 1'b0;

  exp_t txq[2][$];
  exp_t expq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int beats_of(input exp_t t);
    return t.wr ? 1 : int'(t.blk) + 1;
  endfunction

  // Drive both requesters: the front of each pending list, or junk when idle.
  task automatic apply(input bit on0, input bit on1);
    req = {on1, on0};
    if (txq[0].size() > 0) begin
      wr[0] = txq[0][0].wr; addr0 = txq[0][0].addr; wdata0 = txq[0][0].wdata;
      typ0 = txq[0][0].typ; blk0 = txq[0][0].blk;
    end else begin
      wr[0] = 1'($urandom_range(0, 1)); addr0 = $urandom; wdata0 = $urandom;
      typ0 = 3'($urandom_range(0, 7)); blk0 = 4'($urandom_range(0, 15));
    end
    if (txq[1].size() > 0) begin
      wr[1] = txq[1][0].wr; addr1 = txq[1][0].addr; wdata1 = txq[1][0].wdata;
      typ1 = txq[1][0].typ; blk1 = txq[1][0].blk;
    end else begin
      wr[1] = 1'($urandom_range(0, 1)); addr1 = $urandom; wdata1 = $urandom;
      typ1 = 3'($urandom_range(0, 7)); blk1 = 4'($urandom_range(0, 15));
    end
  endtask

  // One round: each requester queues 0..3 transactions; expected grant order
  // comes from the arbitration rule applied to the set of pending requesters.
  task automatic run_round();
    int   n[2];
    bit   late0, late_pend, first, e0, e1;
    bit   on[2];
    int   bc[2];
    logic pick;
    exp_t t;
    exp_t lst[2][$];
    int   tout;
    n[0] = $urandom_range(0, 3);
    n[1] = $urandom_range(0, 3);
    if (n[0] + n[1] == 0) n[$urandom_range(0, 1)] = 1;
    late0 = (n[0] > 0) && (n[1] > 0) && ($urandom_range(0, 3) == 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < n[k]; i++) begin
        t.who = 1'(k);
        t.wr = ($urandom_range(0, 4) < 2);
        t.addr = $urandom; t.wdata = $urandom;
        t.typ = 3'($urandom_range(0, 2));
        t.blk = 4'($urandom_range(0, 15));
        t.drop = 0; t.b2b = 0; t.req_cyc = 0;
        if (k == 1 && i == 0 && late0) begin
          t.wr = 1'b0;
          t.blk = 4'($urandom_range(3, 15));
        end
        if (i == n[k] - 1 && !t.wr && t.blk >= 4'd3 &&
            ($urandom_range(0, 2) == 0 || (k == 1 && late0 && n[1] == 1)))
          t.drop = 1;
        txq[k].push_back(t);
        lst[k].push_back(t);
      end
    end
    first = 1;
    while (lst[0].size() + lst[1].size() > 0) begin
      e0 = (lst[0].size() > 0) && !(first && late0);
      e1 = (lst[1].size() > 0);
      if (e0 && e1) pick = RR ? m_ptr : 1'b0;
      else          pick = e1;
      t = lst[pick].pop_front();
      t.b2b = !first;
      t.req_cyc = cyc;
      expq.push_back(t);
      m_ptr = ~pick;
      first = 0;
    end
    on[0] = (n[0] > 0) && !late0;
    on[1] = (n[1] > 0);
    late_pend = late0;
    bc[0] = 0; bc[1] = 0;
    apply(on[0], on[1]);
    tout = 0;
    while ((txq[0].size() + txq[1].size() > 0) && tout < 2000) begin
      @(negedge clk);
      tout++;
      for (int k = 0; k < 2; k++) begin
        if (wait_o[k] && txq[k].size() > 0) begin
          bc[k]++;
          if (bc[k] == 2) begin
            if (txq[k][0].drop) on[k] = 0;
            if (k == 1 && late_pend) begin on[0] = 1; late_pend = 0; end
          end
          if (bc[k] == beats_of(txq[k][0])) begin
            void'(txq[k].pop_front());
            bc[k] = 0;
            on[k] = (txq[k].size() > 0);
          end
        end
      end
      @(posedge clk); #1;
      apply(on[0], on[1]);
    end
    chk("round_timeout", 64'(tout < 2000), 64'd1);
    txq[0].delete();
    txq[1].delete();
    apply(1'b0, 1'b0);
  endtask

  // AXI master model: captures a request, returns beats with random gaps,
  // and may pulse mem_wait spuriously in the idle cycle after a release.
  initial begin : master_model
    bit m_act, post, was;
    int m_left;
    m_act = 0; post = 0; m_left = 0;
    mif.mem_wait = 1'b0;
    mif.mem_out = 32'd0;
    forever begin
      @(negedge clk);
      if (model_en) begin
        was = m_act;
        if (m_act && mif.mem_wait) begin
          m_left--;
          if (m_left == 0) begin m_act = 0; post = 1; end
        end
        if (!was && mif.mem_req) begin
          m_act = 1;
          m_left = mif.mem_write ? 1 : int'(mif.mem_blk_size) + 1;
        end
      end else begin
        m_act = 0; post = 0;
      end
      @(posedge clk); #1;
      mif.mem_out = $urandom;
      if (!model_en)  mif.mem_wait = dir_wait;
      else if (post) begin mif.mem_wait = 1'($urandom_range(0, 1)); post = 0; end
      else           mif.mem_wait = m_act && ($urandom_range(0, 2) != 0);
    end
  end

  initial begin : monitor
    exp_t       cur;
    bit         act, just_rel, lastb;
    int         bc, rel_cyc;
    logic [1:0] oh;
    logic       exp_req;
    act = 0; just_rel = 0; bc = 0; rel_cyc = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin act = 0; just_rel = 0; continue; end
      chk("rdata", 64'(rdata_o), 64'(mif.mem_out));
      if (just_rel) begin
        chk("release_grant", 64'(grant_o), 64'd0);
        just_rel = 0;
      end
      if (!act) begin
        if (grant_o != 2'b00) begin
          if (expq.size() == 0) begin
            chk("unexpected_grant", 64'(grant_o), 64'd0);
          end else begin
            cur = expq.pop_front();
            act = 1; bc = 0;
            chk("grant_latency", 64'(cyc), 64'(cur.b2b ? rel_cyc + 2 : cur.req_cyc + 1));
          end
        end else begin
          chk("idle_req", 64'(mif.mem_req), 64'd0);
          chk("idle_wait", 64'(wait_o), 64'd0);
          chk("idle_addr", 64'(mif.mem_addr), 64'd0);
          chk("idle_in", 64'(mif.mem_in), 64'd0);
          chk("idle_ctrl", 64'({mif.mem_write, mif.mem_type, mif.mem_blk_size}), 64'd0);
        end
      end
      if (act) begin
        oh = cur.who ? 2'b10 : 2'b01;
        lastb = mif.mem_wait && (bc == beats_of(cur) - 1);
        exp_req = req[cur.who] && !lastb;
        chk("grant", 64'(grant_o), 64'(oh));
        chk("mem_req", 64'(mif.mem_req), 64'(exp_req));
        chk("mem_addr", 64'(mif.mem_addr), 64'(cur.addr));
        chk("mem_in", 64'(mif.mem_in), 64'(cur.wdata));
        chk("mem_ctrl", 64'({mif.mem_write, mif.mem_type, mif.mem_blk_size}),
            64'({cur.wr, cur.typ, cur.blk}));
        chk("wait_o", 64'(wait_o), 64'(mif.mem_wait ? oh : 2'b00));
        if (mif.mem_wait) begin
          bc++;
          if (bc == beats_of(cur)) begin
            act = 0;
            rel_cyc = cyc;
            just_rel = 1;
          end
        end
      end
    end
  end

  initial begin : main
    rstn = 1'b0;
    apply(1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_req", 64'(mif.mem_req), 64'd0);
    chk("rst_wait", 64'(wait_o), 64'd0);
    chk("rst_addr", 64'(mif.mem_addr), 64'd0);
    chk("rst_ctrl", 64'({mif.mem_write, mif.mem_type, mif.mem_blk_size}), 64'd0);
    @(posedge clk); #1;
    apply(1'b0, 1'b0);
    rstn = 1'b1;
    mon_en = 1;
    model_en = 1;
    @(posedge clk); #1;

    for (int r = 0; r < 80; r++) begin
      run_round();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        apply(1'b0, 1'b0);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("expq_empty", 64'(expq.size()), 64'd0);

    // Reset in the middle of a 4-beat read on requester 1.
    mon_en = 0;
    model_en = 0;
    dir_wait = 1'b0;
    @(posedge clk); #1;
    req = 2'b10; wr = 2'b00; addr1 = 32'h0000_1000; blk1 = 4'd3;
    @(negedge clk);
    chk("d_latency_grant", 64'(grant_o), 64'd0);
    @(negedge clk);
    chk("d_grant", 64'(grant_o), 64'h2);
    chk("d_req", 64'(mif.mem_req), 64'd1);
    chk("d_addr", 64'(mif.mem_addr), 64'h1000);
    chk("d_blk", 64'(mif.mem_blk_size), 64'd3);
    dir_wait = 1'b1;
    @(negedge clk);
    chk("d_beat1_wait", 64'(wait_o), 64'h2);
    chk("d_beat1_req", 64'(mif.mem_req), 64'd1);
    chk("d_rdata", 64'(rdata_o), 64'(mif.mem_out));
    dir_wait = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_grant", 64'(grant_o), 64'd0);
    chk("mid_rst_req", 64'(mif.mem_req), 64'd0);
    chk("mid_rst_wait", 64'(wait_o), 64'd0);
    chk("mid_rst_addr", 64'(mif.mem_addr), 64'd0);
    chk("mid_rst_ctrl", 64'({mif.mem_write, mif.mem_type, mif.mem_blk_size}), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    req = 2'b11;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_tie", 64'(grant_o), 64'h1);
    @(posedge clk); #1;
    req = 2'b00;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
